// File: rtl/fp_alu_pkg.sv
// rtl/fp_alu_pkg.sv - shared FP ALU constants: FSM encoding and default field geometry
package fp_alu_pkg;

    localparam int MANTISSA_SIZE = 23;
    localparam int EXPONENT_SIZE = 8;
    localparam int MANT_W        = MANTISSA_SIZE + 1;
    localparam int WORD_W        = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
    localparam int SIGN_POS      = WORD_W - 1;
    localparam int EXP_LSB       = MANTISSA_SIZE;
    localparam int EXP_MSB       = EXP_LSB + EXPONENT_SIZE - 1;
    localparam logic [EXPONENT_SIZE-1:0] EXP_ALL_ONES = {EXPONENT_SIZE{1'b1}};

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] PREP       = 3'd1;
    localparam logic [2:0] ALIGN_LOAD = 3'd2;
    localparam logic [2:0] ALIGN_WAIT = 3'd3;
    localparam logic [2:0] ADD        = 3'd4;
    localparam logic [2:0] NORM_LOAD  = 3'd5;
    localparam logic [2:0] NORM_WAIT  = 3'd6;
    localparam logic [2:0] DONE       = 3'd7;

endpackage

// File: rtl/fp_unpack_compare.sv
// rtl/fp_unpack_compare.sv - unpacks two FP operands and orders them by magnitude
module fp_unpack_compare
    import fp_alu_pkg::*;
#(
    parameter int Mantissa_Size = MANTISSA_SIZE,
    parameter int Exponent_Size = EXPONENT_SIZE
) (
    input  logic [Exponent_Size+Mantissa_Size:0] op_a,
    input  logic [Exponent_Size+Mantissa_Size:0] op_b,
    input  logic                                 sub,
    output logic                                 sign_big,
    output logic                                 sign_small,
    output logic [Exponent_Size-1:0]             exp_big,
    output logic [Mantissa_Size:0]               mant_big,
    output logic [Mantissa_Size:0]               mant_small,
    output logic [Exponent_Size-1:0]             diff,
    output logic                                 a_zero,
    output logic                                 b_zero
);

    localparam int M = Mantissa_Size;
    localparam int E = Exponent_Size;

    logic [E-1:0] exp_a, exp_b, exp_small;
    logic [M:0]   mant_a, mant_b;
    logic         sign_a, sign_b_eff, a_is_big;

    assign sign_a     = op_a[E+M];
    assign sign_b_eff = op_b[E+M] ^ sub;
    assign exp_a      = op_a[E+M-1:M];
    assign exp_b      = op_b[E+M-1:M];

    // No denormals: a zero exponent forces the whole operand to zero
    assign a_zero = (exp_a == '0);
    assign b_zero = (exp_b == '0);
    assign mant_a = a_zero ? '0 : {1'b1, op_a[M-1:0]};
    assign mant_b = b_zero ? '0 : {1'b1, op_b[M-1:0]};

    assign a_is_big = (exp_a > exp_b) || ((exp_a == exp_b) && (mant_a >= mant_b));

    assign sign_big   = a_is_big ? sign_a     : sign_b_eff;
    assign sign_small = a_is_big ? sign_b_eff : sign_a;
    assign exp_big    = a_is_big ? exp_a      : exp_b;
    assign exp_small  = a_is_big ? exp_b      : exp_a;
    assign mant_big   = a_is_big ? mant_a     : mant_b;
    assign mant_small = a_is_big ? mant_b     : mant_a;
    assign diff       = exp_big - exp_small;

endmodule

// File: rtl/fp_addsub_sequencer.sv
// rtl/fp_addsub_sequencer.sv - FP add/sub sequencer driving an external shared mantissa shifter
module fp_addsub_sequencer
    import fp_alu_pkg::*;
#(
    parameter int Mantissa_Size = MANTISSA_SIZE,
    parameter int Exponent_Size = EXPONENT_SIZE
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 sub,
    input  logic [Exponent_Size+Mantissa_Size:0] op_a,
    input  logic [Exponent_Size+Mantissa_Size:0] op_b,
    output logic                                 busy,
    output logic                                 valid,
    output logic [Exponent_Size+Mantissa_Size:0] result,
    output logic                                 overflow,
    output logic                                 underflow,
    output logic                                 sh_enable,
    output logic                                 sh_load,
    output logic                                 sh_direction,
    output logic [Mantissa_Size:0]               sh_mantissa,
    output logic [Exponent_Size-1:0]             sh_exponent,
    output logic [Exponent_Size-1:0]             sh_no_of_shifts,
    input  logic                                 sh_done,
    input  logic                                 sh_underflow,
    input  logic [Mantissa_Size:0]               sh_mantissa_in,
    input  logic [Exponent_Size-1:0]             sh_exponent_in
);

    localparam int M = Mantissa_Size;
    localparam int E = Exponent_Size;
    localparam logic [E-1:0] EXP_ONES = {E{1'b1}};

    logic [2:0]   state;
    logic         first_wait;
    logic         sign_big_q, sign_small_q, a_zero_q, b_zero_q;
    logic [E-1:0] exp_big_q, diff_q;
    logic [M:0]   mant_big_q, mant_small_q;

    logic         u_sign_big, u_sign_small, u_a_zero, u_b_zero;
    logic [E-1:0] u_exp_big, u_diff;
    logic [M:0]   u_mant_big, u_mant_small;

    logic [M+1:0] sum;
    logic [M:0]   diff_mant;
    logic [E-1:0] exp_inc;
    logic         eff_add;

    fp_unpack_compare #(
        .Mantissa_Size(Mantissa_Size),
        .Exponent_Size(Exponent_Size)
    ) u_unpack (
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .sign_big  (u_sign_big),
        .sign_small(u_sign_small),
        .exp_big   (u_exp_big),
        .mant_big  (u_mant_big),
        .mant_small(u_mant_small),
        .diff      (u_diff),
        .a_zero    (u_a_zero),
        .b_zero    (u_b_zero)
    );

    assign sum       = {1'b0, mant_big_q} + {1'b0, mant_small_q};
    assign diff_mant = mant_big_q - mant_small_q;
    assign exp_inc   = exp_big_q + 1'b1;
    assign eff_add   = (sign_big_q == sign_small_q);

    assign busy            = (state != IDLE) && (state != DONE);
    assign valid           = (state == DONE);
    assign sh_enable       = (state == ALIGN_LOAD) || (state == ALIGN_WAIT) ||
                             (state == NORM_LOAD)  || (state == NORM_WAIT);
    assign sh_load         = (state == ALIGN_LOAD) || (state == NORM_LOAD);
    assign sh_direction    = (state == ALIGN_LOAD) || (state == ALIGN_WAIT);
    assign sh_mantissa     = sh_direction ? mant_small_q : mant_big_q;
    assign sh_exponent     = exp_big_q;
    assign sh_no_of_shifts = sh_direction ? diff_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            first_wait <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_big_q   <= u_sign_big;
                        sign_small_q <= u_sign_small;
                        exp_big_q    <= u_exp_big;
                        mant_big_q   <= u_mant_big;
                        mant_small_q <= u_mant_small;
                        diff_q       <= u_diff;
                        a_zero_q     <= u_a_zero;
                        b_zero_q     <= u_b_zero;
                        overflow     <= 1'b0;
                        underflow    <= 1'b0;
                        state        <= PREP;
                    end
                end
                PREP: begin
                    // With one operand zero the big side is the other one; with both zero, B wins
                    if (a_zero_q || b_zero_q) begin
                        result <= {(a_zero_q && b_zero_q) ? sign_small_q : sign_big_q,
                                   exp_big_q, mant_big_q[M-1:0]};
                        state  <= DONE;
                    end else if (diff_q == '0) begin
                        state <= ADD;
                    end else begin
                        state <= ALIGN_LOAD;
                    end
                end
                ALIGN_LOAD: begin
                    first_wait <= 1'b1;
                    state      <= ALIGN_WAIT;
                end
                ALIGN_WAIT: begin
                    if (first_wait) begin
                        first_wait <= 1'b0;
                    end else if (sh_done) begin
                        mant_small_q <= sh_mantissa_in;
                        state        <= ADD;
                    end
                end
                ADD: begin
                    state <= DONE;
                    if (eff_add) begin
                        if (sum[M+1]) begin
                            if (exp_inc == EXP_ONES) begin
                                overflow <= 1'b1;
                                result   <= {sign_big_q, EXP_ONES, {M{1'b0}}};
                            end else begin
                                result <= {sign_big_q, exp_inc, sum[M:1]};
                            end
                        end else begin
                            result <= {sign_big_q, exp_big_q, sum[M-1:0]};
                        end
                    end else if (diff_mant == '0) begin
                        result <= '0;
                    end else if (diff_mant[M]) begin
                        result <= {sign_big_q, exp_big_q, diff_mant[M-1:0]};
                    end else begin
                        mant_big_q <= diff_mant;
                        state      <= NORM_LOAD;
                    end
                end
                NORM_LOAD: begin
                    first_wait <= 1'b1;
                    state      <= NORM_WAIT;
                end
                NORM_WAIT: begin
                    if (first_wait) begin
                        first_wait <= 1'b0;
                    end else if (sh_done) begin
                        if (sh_underflow) begin
                            result    <= {sign_big_q, {(E+M){1'b0}}};
                            underflow <= 1'b1;
                        end else begin
                            result <= {sign_big_q, sh_exponent_in, sh_mantissa_in[M-1:0]};
                        end
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// tb/tb_fp_addsub_sequencer.sv - directed bench with a behavioural shifter beside the sequencer
module tb_fp_addsub_sequencer;
    import fp_alu_pkg::*;

    localparam int W  = WORD_W;
    localparam int MW = MANT_W;

    logic           clk = 1'b0;
    logic           rst_n, start, sub;
    logic [W-1:0]   op_a, op_b, result;
    logic           busy, valid, overflow, underflow;
    logic           sh_enable, sh_load, sh_direction;
    logic [MW-1:0]  sh_mantissa, sh_mantissa_in;
    logic [7:0]     sh_exponent, sh_no_of_shifts, sh_exponent_in;
    logic           sh_done, sh_underflow;

    int checks = 0;
    int passes = 0;
    int load_cnt = 0;
    int valid_cnt = 0;
    logic       last_dir;
    logic [7:0] last_nsh;
    int         pend;

    logic [W-1:0] r_res;
    logic         r_ovf, r_unf, r_busy, r_seen;
    int           r_loads, r_valids;

    always #5 clk = ~clk;

    fp_addsub_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b), .busy(busy), .valid(valid),
        .result(result), .overflow(overflow), .underflow(underflow),
        .sh_enable(sh_enable), .sh_load(sh_load), .sh_direction(sh_direction),
        .sh_mantissa(sh_mantissa), .sh_exponent(sh_exponent),
        .sh_no_of_shifts(sh_no_of_shifts), .sh_done(sh_done),
        .sh_underflow(sh_underflow), .sh_mantissa_in(sh_mantissa_in),
        .sh_exponent_in(sh_exponent_in)
    );

    function automatic logic [32:0] norm_left(input logic [23:0] m_in, input logic [7:0] e_in);
        logic [23:0] m;
        logic [7:0]  e;
        logic        uf;
        m  = m_in;
        e  = e_in;
        uf = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (!m[23] && !uf) begin
                m = m << 1;
                if (e <= 8'd1) uf = 1'b1;
                else e = e - 8'd1;
            end
        end
        return {uf, e, m};
    endfunction

    always @(posedge clk) begin
        if (valid) valid_cnt <= valid_cnt + 1;
        if (!rst_n) begin
            pend         <= 0;
            sh_done      <= 1'b0;
            sh_underflow <= 1'b0;
        end else if (sh_enable && sh_load) begin
            load_cnt <= load_cnt + 1;
            last_dir <= sh_direction;
            last_nsh <= sh_no_of_shifts;
            pend     <= 3;
            sh_done  <= 1'b0;
            if (sh_direction) begin
                sh_mantissa_in <= (sh_no_of_shifts >= 8'd24) ? 24'd0 : (sh_mantissa >> sh_no_of_shifts);
                sh_exponent_in <= sh_exponent;
                sh_underflow   <= 1'b0;
            end else begin
                {sh_underflow, sh_exponent_in, sh_mantissa_in} <= norm_left(sh_mantissa, sh_exponent);
            end
        end else if (pend > 1) begin
            pend <= pend - 1;
        end else if (pend == 1) begin
            pend    <= 0;
            sh_done <= 1'b1;
        end else begin
            sh_done <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int l0, v0;
        l0 = load_cnt;
        v0 = valid_cnt;
        @(negedge clk);
        op_a = a; op_b = b; sub = s; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        r_busy = busy;
        r_seen = 1'b0;
        for (int i = 0; i < 200 && !r_seen; i++) begin
            if (valid) r_seen = 1'b1;
            else @(negedge clk);
        end
        r_res = result;
        r_ovf = overflow;
        r_unf = underflow;
        repeat (3) @(negedge clk);
        r_loads  = load_cnt - l0;
        r_valids = valid_cnt - v0;
        check("valid_seen", {31'd0, r_seen}, 32'd1);
        check("result_held", result, r_res);
    endtask

    initial begin
        int l0, v0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        check("rst_sh_ctl", {29'd0, sh_enable, sh_load, sh_direction}, 32'd0);
        rst_n = 1'b1;

        run_op(32'h3F800000, 32'h3F800000, 1'b0);
        check("add_1p1_busy", {31'd0, r_busy}, 32'd1);
        check("add_1p1_res", r_res, 32'h40000000);
        check("add_1p1_flags", {30'd0, r_ovf, r_unf}, 32'd0);
        check("add_1p1_loads", r_loads, 32'd0);

        run_op(32'h3FC00000, 32'h3F800000, 1'b1);
        check("sub_norm_res", r_res, 32'h3F000000);
        check("sub_norm_loads", r_loads, 32'd1);
        check("sub_norm_dir", {31'd0, last_dir}, 32'd0);
        check("sub_norm_valids", r_valids, 32'd1);

        run_op(32'h3F800000, 32'h30800000, 1'b0);
        check("align30_res", r_res, 32'h3F800000);
        check("align30_loads", r_loads, 32'd1);
        check("align30_nsh", {24'd0, last_nsh}, 32'd30);
        check("align30_dir", {31'd0, last_dir}, 32'd1);

        run_op(32'h40400000, 32'h40400000, 1'b1);
        check("cancel_res", r_res, 32'h00000000);
        check("cancel_flags", {30'd0, r_ovf, r_unf}, 32'd0);
        check("cancel_loads", r_loads, 32'd0);

        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
        check("ovf_res", r_res, {1'b0, EXP_ALL_ONES, 23'd0});
        check("ovf_flag", {31'd0, r_ovf}, 32'd1);

        run_op(32'h00000000, 32'h3F800000, 1'b1);
        check("zero_a_res", r_res, 32'hBF800000);
        check("zero_a_loads", r_loads, 32'd0);

        l0 = load_cnt;
        v0 = valid_cnt;
        @(negedge clk);
        op_a = 32'h40000000; op_b = 32'h3F800000; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && load_cnt == l0; i++) @(negedge clk);
        check("abort_load_seen", load_cnt - l0, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sh_enable", {31'd0, sh_enable}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_valid", valid_cnt - v0, 32'd0);

        run_op(32'h40000000, 32'h3F800000, 1'b0);
        check("after_abort_res", r_res, 32'h40400000);
        check("after_abort_loads", r_loads, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
